mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV32I pipeline. It handles variable-latency memory with a request/ready handshake and gives data accesses priority, with a bounded-starvation guarantee for fetch. It returns read data to each requester and drives per-stage stall signals for the hazard logic.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_timeout.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

    // Data wins ties unless fetch has already waited out a full data streak.
    function automatic port_e pick_port(input logic i_elig, input logic d_elig,
                                        input logic streak_full);
        if (d_elig && !(i_elig && streak_full)) begin
            return PORT_D;
        end
        return PORT_I;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable saturating wait counter; expired_o flags the last permitted wait cycle.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// data-first with a bounded fetch starvation window and a per-access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wr_data_i,
    input  logic [3:0]            d_byte_en_i,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_f_o,
    output logic                  stall_m_o,
    output logic                  err_o
);

    localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic [StreakW-1:0]    streak_q, streak_d;

    logic  if_elig, d_elig;
    logic  tmo_clr, tmo_en, tmo_expired;
    port_e grant;

    // A request still high in its own completion cycle is stale, not a new one.
    assign if_elig = if_req_i & ~if_valid_q;
    assign d_elig  = d_req_i & ~d_valid_q;

    mem_arb_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .load_i    (1'b0),
        .load_val_i('0),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        streak_d   = streak_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        grant      = pick_port(if_elig, d_elig, streak_q == StreakMax);

        unique case (state_q)
            IDLE: begin
                if (if_elig || d_elig) begin
                    tmo_clr = 1'b1;
                    if (grant == PORT_D) begin
                        state_d = D_WAIT;
                        addr_d  = d_addr_i;
                        wdata_d = d_wr_data_i;
                        be_d    = d_byte_en_i;
                        we_d    = d_wr_en_i;
                        if (if_elig && streak_q != StreakMax) begin
                            streak_d = streak_q + StreakW'(1);
                        end
                    end else begin
                        state_d  = I_WAIT;
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        be_d     = FETCH_BE;
                        we_d     = 1'b0;
                        streak_d = '0;
                    end
                end
            end
            I_WAIT, D_WAIT: begin
                if (mem_ready_i || tmo_expired) begin
                    state_d = IDLE;
                    err_d   = ~mem_ready_i;
                    if (state_q == I_WAIT) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready_i ? mem_rdata_i : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = (mem_ready_i && !we_q) ? mem_rdata_i : '0;
                    end
                end else begin
                    tmo_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            streak_q   <= streak_d;
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign stall_f_o   = if_req_i & ~if_valid_q;
    assign stall_m_o   = d_req_i & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus starvation, timeout and reset sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_wr_en_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wr_data_i;
    logic [3:0]  d_byte_en_i;
    logic        d_valid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        stall_f_o;
    logic        stall_m_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MAX_D_STREAK(4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_valid_o (if_valid_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_wr_en_i  (d_wr_en_i),
        .d_addr_i   (d_addr_i),
        .d_wr_data_i(d_wr_data_i),
        .d_byte_en_i(d_byte_en_i),
        .d_valid_o  (d_valid_o),
        .d_rdata_o  (d_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i),
        .stall_f_o  (stall_f_o),
        .stall_m_o  (stall_m_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_iv;
        logic        e_dv;
        logic [31:0] e_data;
        logic        e_sf;
        logic        e_sm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic if_req, input logic d_req, input logic rdy,
                                input logic [31:0] rdata, input logic e_req, input logic e_we,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic e_iv, input logic e_dv, input logic [31:0] e_data,
                                input logic e_sf, input logic e_sm);
        vec_t v;
        v.if_req = if_req; v.d_req = d_req; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_be = e_be;
        v.e_iv = e_iv; v.e_dv = e_dv; v.e_data = e_data; v.e_sf = e_sf; v.e_sm = e_sm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req_i = 1'b0; d_req_i = 1'b0; mem_ready_i = 1'b0; mem_rdata_i = '0;
        tick();
        tick();
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_valids", {29'b0, if_valid_o, d_valid_o, err_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_addr_i   = 32'h0000_0010;
        d_addr_i    = 32'h0000_0100;
        d_wr_en_i   = 1'b1;
        d_wr_data_i = 32'hDEAD_BEEF;
        d_byte_en_i = 4'b0011;

        // Single fetch (L=3) with stale request held through the valid cycle.
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,     4'h0, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            1, 0, 32'h10, 4'hF, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            1, 0, 32'h10, 4'hF, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            1, 0, 32'h10, 4'hF, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h0051_3023, 1, 0, 32'h10, 4'hF, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,     4'h0, 1, 0, 32'h0051_3023, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,     4'h0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,     4'h0, 0, 0, 0,            0, 0));
        // Simultaneous fetch and store: store first, fetch granted in the d_valid cycle.
        vecs.push_back(mk(1, 1, 0, 0,            0, 0, 0,      4'h0, 0, 0, 0,            1, 1));
        vecs.push_back(mk(1, 1, 0, 0,            1, 1, 32'h100, 4'h3, 0, 0, 0,            1, 1));
        vecs.push_back(mk(1, 1, 1, 32'h1234_5678, 1, 1, 32'h100, 4'h3, 0, 0, 0,            1, 1));
        vecs.push_back(mk(1, 1, 0, 0,            0, 0, 0,      4'h0, 0, 1, 0,            1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hCAFE_F00D, 1, 0, 32'h10,  4'hF, 0, 0, 0,            1, 0));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0, 0,      4'h0, 1, 0, 32'hCAFE_F00D, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      4'h0, 0, 0, 0,            0, 0));

        do_reset();

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if_req_i = v.if_req; d_req_i = v.d_req;
            mem_ready_i = v.rdy; mem_rdata_i = v.rdata;
            #1;
            check($sformatf("v%0d_mem_req", i), {31'b0, mem_req_o}, {31'b0, v.e_req});
            check($sformatf("v%0d_if_valid", i), {31'b0, if_valid_o}, {31'b0, v.e_iv});
            check($sformatf("v%0d_d_valid", i), {31'b0, d_valid_o}, {31'b0, v.e_dv});
            check($sformatf("v%0d_stall_f", i), {31'b0, stall_f_o}, {31'b0, v.e_sf});
            check($sformatf("v%0d_stall_m", i), {31'b0, stall_m_o}, {31'b0, v.e_sm});
            check($sformatf("v%0d_err", i), {31'b0, err_o}, 32'd0);
            if (v.e_req) begin
                check($sformatf("v%0d_mem_addr", i), mem_addr_o, v.e_addr);
                check($sformatf("v%0d_mem_we", i), {31'b0, mem_we_o}, {31'b0, v.e_we});
                check($sformatf("v%0d_mem_be", i), {28'b0, mem_be_o}, {28'b0, v.e_be});
                if (v.e_we) check($sformatf("v%0d_mem_wdata", i), mem_wdata_o, 32'hDEAD_BEEF);
            end
            if (v.e_iv) check($sformatf("v%0d_if_rdata", i), if_rdata_o, v.e_data);
            if (v.e_dv) check($sformatf("v%0d_d_rdata", i), d_rdata_o, v.e_data);
            @(posedge clk);
            #1;
        end

        // Starvation bound: fetch dropped only in d_valid cycles so both are eligible at each grant.
        do_reset();
        begin
            int   d_grants = 0;
            logic f_granted = 1'b0;
            logic prev_req = 1'b0;
            if_addr_i = 32'h40; d_addr_i = 32'h200; d_wr_en_i = 1'b0; mem_rdata_i = 32'h77;
            if_req_i = 1'b1; d_req_i = 1'b1;
            for (int c = 0; c < 200 && !f_granted; c++) begin
                tick();
                if (mem_req_o && !prev_req) begin
                    if (mem_addr_o == 32'h200) begin
                        d_grants++;
                        if (d_grants == 4) check("starve_streak_full", {29'b0, dut.streak_q}, 32'd4);
                    end else begin
                        f_granted = 1'b1;
                        check("starve_d_grants", d_grants, 32'd4);
                        check("starve_fetch_addr", mem_addr_o, 32'h40);
                        check("starve_streak_clr", {29'b0, dut.streak_q}, 32'd0);
                    end
                end
                prev_req = mem_req_o;
                if_req_i = ~d_valid_o;
                mem_ready_i = mem_req_o;
            end
            check("starve_fetch_granted", {31'b0, f_granted}, 32'd1);
        end

        // Timeout: memory never ready on a load.
        do_reset();
        begin
            int   req_cycles = 0;
            logic seen = 1'b0;
            d_addr_i = 32'h300; d_wr_en_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
            d_req_i = 1'b1;
            for (int c = 0; c < 100 && !seen; c++) begin
                tick();
                if (d_valid_o) begin
                    seen = 1'b1;
                    check("tmo_err", {31'b0, err_o}, 32'd1);
                    check("tmo_rdata", d_rdata_o, 32'd0);
                    check("tmo_idle", {31'b0, dut.state_q == IDLE}, 32'd1);
                    check("tmo_mem_req", {31'b0, mem_req_o}, 32'd0);
                    d_req_i = 1'b0;
                end else if (mem_req_o) begin
                    req_cycles++;
                end
            end
            check("tmo_seen", {31'b0, seen}, 32'd1);
            check("tmo_wait_cycles", req_cycles, 32'd64);
            tick();
            check("tmo_err_one_cycle", {30'b0, err_o, d_valid_o}, 32'd0);
        end

        // Reset dropped during D_WAIT, then a normal fetch.
        do_reset();
        begin
            int   pulses = 0;
            logic seen = 1'b0;
            d_addr_i = 32'h100; d_wr_en_i = 1'b1; d_req_i = 1'b1;
            tick();
            tick();
            check("rmid_in_dwait", {31'b0, mem_req_o}, 32'd1);
            rst_n = 1'b0;
            d_req_i = 1'b0;
            #1;
            check("rmid_req_drop", {31'b0, mem_req_o}, 32'd0);
            tick();
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (d_valid_o || if_valid_o) pulses++;
            end
            check("rmid_no_valid", pulses, 32'd0);
            if_addr_i = 32'h80; mem_rdata_i = 32'hA5A5_0001; if_req_i = 1'b1;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (if_valid_o) begin
                    seen = 1'b1;
                    check("rmid_fetch_rdata", if_rdata_o, 32'hA5A5_0001);
                    if_req_i = 1'b0;
                end
                mem_ready_i = mem_req_o;
            end
            check("rmid_fetch_done", {31'b0, seen}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
